// File: rtl/icache_way_store_pkg.sv
// Shared constants, tag entry type and parameter legality helpers for the icache way store.
// No logic; the tag entry type here matches the default tag width.
package icache_pkg;

  localparam int WORD_W             = 32;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_SET_NUM        = 256;
  localparam int DEF_FETCH_SIZE     = 2;
  localparam int DEF_TAG_WIDTH      = 21;

  localparam int IDX_W  = $clog2(DEF_SET_NUM);
  localparam int WOFF_W = $clog2(DEF_WORDS_PER_LINE);

  typedef struct packed {
    logic                     valid;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int wpl, input int sets, input int fetch, input int tagw);
    return is_pow2(wpl) && (wpl >= 2) && (wpl <= 16) &&
           is_pow2(sets) && (sets >= 16) && (sets <= 1024) &&
           ((fetch == 1) || (fetch == 2) || (fetch == 4)) && (fetch <= wpl) &&
           (tagw >= 1);
  endfunction

endpackage

// File: rtl/icache_way_store_if.sv
// Request/response bundle between the icache controller (master) and one way store (slave).
// Reads return one cycle after acceptance; there is no backpressure.
interface icache_way_store_if #(
  parameter int WORDS_PER_LINE = icache_pkg::DEF_WORDS_PER_LINE,
  parameter int SET_NUM        = icache_pkg::DEF_SET_NUM,
  parameter int FETCH_SIZE     = icache_pkg::DEF_FETCH_SIZE,
  parameter int TAG_WIDTH      = icache_pkg::DEF_TAG_WIDTH
);
  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);

  logic                     init_done_o;
  logic [IDX_W+WOFF_W-1:0]  addr_i;
  logic                     rd_en_i;
  logic                     data_we_i;
  logic [31:0]              data_i;
  logic                     tag_we_i;
  logic [TAG_WIDTH-1:0]     tag_i;
  logic                     valid_i;
  logic                     rd_valid_o;
  logic [FETCH_SIZE*32-1:0] data_o;
  logic [TAG_WIDTH-1:0]     tag_o;
  logic                     valid_o;

  modport master (
    input  init_done_o, rd_valid_o, data_o, tag_o, valid_o,
    output addr_i, rd_en_i, data_we_i, data_i, tag_we_i, tag_i, valid_i
  );

  modport slave (
    output init_done_o, rd_valid_o, data_o, tag_o, valid_o,
    input  addr_i, rd_en_i, data_we_i, data_i, tag_we_i, tag_i, valid_i
  );
endinterface

// File: rtl/icache_way_store_spram.sv
// Behavioural single-port RAM, synchronous read, read port holds while disabled or writing.
// Latency 1 cycle; no backpressure.
module icache_spram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register only updates on a pure read, so it doubles as the hold register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/icache_way_store.sv
// One icache way: per-word data banks plus a tag/valid array, swept clear after reset.
// Read latency 1 cycle; writes win over a coincident read; outputs hold until the next read.
module icache_way_store
  import icache_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int SET_NUM        = DEF_SET_NUM,
  parameter int FETCH_SIZE     = DEF_FETCH_SIZE,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  icache_way_store_if.slave bus
);

  localparam int IDX_BITS  = $clog2(SET_NUM);
  localparam int WOFF_BITS = $clog2(WORDS_PER_LINE);
  localparam logic [WOFF_BITS-1:0] GROUP_MASK = ~WOFF_BITS'(FETCH_SIZE - 1);
  localparam logic [IDX_BITS-1:0]  LAST_SET   = IDX_BITS'(SET_NUM - 1);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } way_tag_t;

  if (!params_ok(WORDS_PER_LINE, SET_NUM, FETCH_SIZE, TAG_WIDTH)) begin : g_param_check
    $error("icache_way_store: illegal parameter set");
  end

  logic [0:0]           state;
  logic [IDX_BITS-1:0]  sweep_cnt;
  logic                 run;
  logic                 rd_acc;
  logic                 rd_valid_q;
  logic [IDX_BITS-1:0]  idx;
  logic [WOFF_BITS-1:0] woff;
  logic [WOFF_BITS-1:0] base_q;

  assign {idx, woff} = bus.addr_i;
  assign run    = (state == ST_RUN);
  assign rd_acc = run & bus.rd_en_i & ~bus.data_we_i & ~bus.tag_we_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == LAST_SET) begin
        state <= ST_RUN;
      end
    end
  end

  // base_q remembers which fetch group the held bank outputs belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      base_q     <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        base_q <= woff & GROUP_MASK;
      end
    end
  end

  logic                tag_en;
  logic                tag_we;
  logic [IDX_BITS-1:0] tag_addr;
  way_tag_t            tag_wdata;
  way_tag_t            tag_q;

  always_comb begin
    tag_we    = 1'b0;
    tag_en    = 1'b0;
    tag_addr  = idx;
    tag_wdata = '0;
    if (!run) begin
      tag_we   = rst_n;
      tag_en   = rst_n;
      tag_addr = sweep_cnt;
    end else begin
      tag_we    = rst_n & bus.tag_we_i;
      tag_en    = tag_we | rd_acc;
      tag_wdata = '{valid: bus.valid_i, tag: bus.tag_i};
    end
  end

  icache_spram #(
    .DEPTH (SET_NUM),
    .WIDTH (TAG_WIDTH + 1)
  ) u_tag_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tag_en),
    .we    (tag_we),
    .addr  (tag_addr),
    .wdata (tag_wdata),
    .rdata (tag_q)
  );

  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] bank_q;

  for (genvar b = 0; b < WORDS_PER_LINE; b++) begin : g_bank
    logic bank_we;
    assign bank_we = run & rst_n & bus.data_we_i & (woff == WOFF_BITS'(b));

    icache_spram #(
      .DEPTH (SET_NUM),
      .WIDTH (WORD_W)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bank_we | rd_acc),
      .we    (bank_we),
      .addr  (idx),
      .wdata (bus.data_i),
      .rdata (bank_q[b])
    );
  end

  always_comb begin
    bus.data_o = '0;
    for (int w = 0; w < FETCH_SIZE; w++) begin
      bus.data_o[w*WORD_W +: WORD_W] = bank_q[base_q + WOFF_BITS'(w)];
    end
  end

  assign bus.init_done_o = run;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.tag_o       = tag_q.tag;
  assign bus.valid_o     = tag_q.valid;

endmodule

// File: tb/tb_icache_way_store.sv
// Bench for icache_way_store: a default-size way (256 sets, fetch 2) and a small way
// (16 sets, fetch 4), checked against a vector table, a read scoreboard and hand sequences.
module tb_icache_way_store;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_way_store_if #(.WORDS_PER_LINE(4), .SET_NUM(256), .FETCH_SIZE(2), .TAG_WIDTH(21)) bus_a ();
  icache_way_store_if #(.WORDS_PER_LINE(4), .SET_NUM(16),  .FETCH_SIZE(4), .TAG_WIDTH(21)) bus_b ();

  icache_way_store #(.WORDS_PER_LINE(4), .SET_NUM(256), .FETCH_SIZE(2), .TAG_WIDTH(21)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a)
  );
  icache_way_store #(.WORDS_PER_LINE(4), .SET_NUM(16), .FETCH_SIZE(4), .TAG_WIDTH(21)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b)
  );

  typedef struct {
    logic        rd, dwe, twe;
    logic [7:0]  set;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [20:0] wtag;
    logic        wvalid;
    logic        acc;
    logic [63:0] exp_data;
    logic [20:0] exp_tag;
    logic        exp_valid;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [20:0] tag;
    logic        valid;
    logic        chk_data;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[21];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic dwe, input logic twe,
                              input logic [7:0] set, input logic [1:0] off,
                              input logic [31:0] wd, input logic [20:0] wt, input logic wv,
                              input logic acc, input logic [63:0] ed, input logic [20:0] et,
                              input logic ev, input logic cd);
    vec_t v;
    v.rd = rd; v.dwe = dwe; v.twe = twe; v.set = set; v.off = off;
    v.wdata = wd; v.wtag = wt; v.wvalid = wv;
    v.acc = acc; v.exp_data = ed; v.exp_tag = et; v.exp_valid = ev; v.chk_data = cd;
    return v;
  endfunction

  function automatic vec_t wr(input logic [7:0] set, input logic [1:0] off, input logic [31:0] d);
    return mk(0, 1, 0, set, off, d, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t tw(input logic [7:0] set, input logic [20:0] t, input logic v);
    return mk(0, 0, 1, set, 0, 0, t, v, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rdx(input logic [7:0] set, input logic [1:0] off,
                               input logic [63:0] ed, input logic [20:0] et, input logic ev);
    return mk(1, 0, 0, set, off, 0, 0, 0, 1, ed, et, ev, 1);
  endfunction

  task automatic drive_a(input vec_t t, input int id);
    @(posedge clk); #1;
    bus_a.rd_en_i   = t.rd;
    bus_a.data_we_i = t.dwe;
    bus_a.tag_we_i  = t.twe;
    bus_a.addr_i    = {t.set, t.off};
    bus_a.data_i    = t.wdata;
    bus_a.tag_i     = t.wtag;
    bus_a.valid_i   = t.wvalid;
    if (t.acc) sbq.push_back('{t.exp_data, t.exp_tag, t.exp_valid, t.chk_data, cyc, id});
  endtask

  task automatic idle_a();
    drive_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
  endtask

  task automatic chk_zero_a(input string p);
    chk({p, "_init_done"}, bus_a.init_done_o, 0);
    chk({p, "_rd_valid"},  bus_a.rd_valid_o, 0);
    chk({p, "_data"},      bus_a.data_o, 0);
    chk({p, "_tag"},       bus_a.tag_o, 0);
    chk({p, "_valid"},     bus_a.valid_o, 0);
  endtask

  // Counts edges from the first one with reset released; init_done must first show after edge 256.
  task automatic sweep_a(input string p);
    bit early = 0;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 256 && bus_a.init_done_o) early = 1;
      if (k == 256) chk({p, "_init_done"}, bus_a.init_done_o, 1);
    end
    chk({p, "_init_low"}, early, 0);
    bus_a.rd_en_i  = 1'b0;
    bus_a.tag_we_i = 1'b0;
  endtask

  // Scoreboard: an accepted read must show rd_valid exactly one cycle later with the table values.
  always @(negedge clk) begin
    if (sbq.size() != 0 && sbq[0].cyc + 1 == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk($sformatf("rd%0d_valid", e.id), bus_a.rd_valid_o, 1);
      chk($sformatf("rd%0d_tag", e.id),   bus_a.tag_o, e.tag);
      chk($sformatf("rd%0d_vbit", e.id),  bus_a.valid_o, e.valid);
      if (e.chk_data) chk($sformatf("rd%0d_data", e.id), bus_a.data_o, e.data);
    end else if (bus_a.rd_valid_o) begin
      chk($sformatf("rd_valid_spurious_cyc%0d", cyc), bus_a.rd_valid_o, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 8'h3F, 0, 0, 0, 0, 1, 0, 21'h0, 0, 0);
    tbl[1]  = wr(8'h05, 0, 32'h11);
    tbl[2]  = wr(8'h05, 1, 32'h22);
    tbl[3]  = wr(8'h05, 2, 32'h33);
    tbl[4]  = wr(8'h05, 3, 32'h44);
    tbl[5]  = tw(8'h05, 21'h1ABCD, 1);
    tbl[6]  = rdx(8'h05, 3, 64'h00000044_00000033, 21'h1ABCD, 1);
    tbl[7]  = rdx(8'h05, 1, 64'h00000022_00000011, 21'h1ABCD, 1);
    tbl[8]  = mk(0, 1, 1, 8'h06, 2, 32'hCAFE0002, 21'h0F00F, 1, 0, 0, 0, 0, 0);
    tbl[9]  = wr(8'h06, 3, 32'hCAFE0003);
    tbl[10] = rdx(8'h06, 2, 64'hCAFE0003_CAFE0002, 21'h0F00F, 1);
    tbl[11] = wr(8'hFF, 3, 32'hDEAD00FF);
    tbl[12] = wr(8'hFF, 2, 32'hBEEF00FE);
    tbl[13] = tw(8'hFF, 21'h1FFFFF, 0);
    tbl[14] = rdx(8'hFF, 3, 64'hDEAD00FF_BEEF00FE, 21'h1FFFFF, 0);
    tbl[15] = mk(1, 1, 0, 8'h05, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = rdx(8'h05, 0, 64'h00000022_00000099, 21'h1ABCD, 1);
    tbl[17] = mk(1, 0, 1, 8'h05, 0, 0, 21'h12345, 0, 0, 0, 0, 0, 0);
    tbl[18] = rdx(8'h05, 2, 64'h00000044_00000033, 21'h12345, 0);
    tbl[19] = rdx(8'h05, 2, 64'h00000044_00000033, 21'h0, 0);
    tbl[20] = rdx(8'h06, 2, 64'hCAFE0003_CAFE0002, 21'h0, 0);

    rst_a = 0; rst_b = 0;
    bus_a.rd_en_i = 0; bus_a.data_we_i = 0; bus_a.tag_we_i = 0;
    bus_a.addr_i = '0; bus_a.data_i = '0; bus_a.tag_i = '0; bus_a.valid_i = 0;
    bus_b.rd_en_i = 0; bus_b.data_we_i = 0; bus_b.tag_we_i = 0;
    bus_b.addr_i = '0; bus_b.data_i = '0; bus_b.tag_i = '0; bus_b.valid_i = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_a("reset");

    // Requests raised during the sweep must be ignored.
    bus_a.rd_en_i = 1; bus_a.tag_we_i = 1; bus_a.valid_i = 1;
    bus_a.tag_i = 21'h01234; bus_a.addr_i = {8'h3F, 2'd0};
    @(posedge clk); #1;
    rst_a = 1;
    sweep_a("sweep1");

    for (int i = 0; i < 19; i++) drive_a(tbl[i], i);

    // Hold: outputs from read 18 persist through idles and writes.
    for (int k = 0; k < 12; k++) begin
      if (k == 5)      drive_a(wr(8'h07, 1, 32'h77), -1);
      else if (k == 8) drive_a(tw(8'h07, 21'h00777, 1), -1);
      else             idle_a();
      @(negedge clk);
      chk($sformatf("hold%0d_data", k), bus_a.data_o, 64'h00000044_00000033);
      chk($sformatf("hold%0d_tag", k), bus_a.tag_o, 21'h12345);
      if (k >= 1) chk($sformatf("hold%0d_rd_valid", k), bus_a.rd_valid_o, 0);
    end

    @(posedge clk); #1;
    rst_a = 0;
    @(posedge clk);
    @(negedge clk);
    chk_zero_a("run_reset");
    @(posedge clk); #1;
    rst_a = 1;
    repeat (100) @(posedge clk);
    #1 rst_a = 0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1;
    sweep_a("sweep2");

    for (int i = 19; i < 21; i++) drive_a(tbl[i], i);
    repeat (2) idle_a();
    @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    // Small way: whole-line fetch from the last set.
    @(negedge clk);
    chk("b_reset_data", bus_b.data_o, 0);
    @(posedge clk); #1;
    rst_b = 1;
    begin
      bit early = 0;
      for (int k = 1; k <= 16; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k < 16 && bus_b.init_done_o) early = 1;
      end
      chk("b_init_low", early, 0);
      chk("b_init_done", bus_b.init_done_o, 1);
    end
    for (int o = 0; o < 4; o++) begin
      @(posedge clk); #1;
      bus_b.data_we_i = 1;
      bus_b.addr_i    = {4'hF, 2'(o)};
      bus_b.data_i    = 32'hB0B00000 + 32'(o);
    end
    @(posedge clk); #1;
    bus_b.data_we_i = 0; bus_b.tag_we_i = 1; bus_b.tag_i = 21'h0BEEF; bus_b.valid_i = 1;
    @(posedge clk); #1;
    bus_b.tag_we_i = 0; bus_b.rd_en_i = 1; bus_b.addr_i = {4'hF, 2'd1};
    @(posedge clk); #1;
    bus_b.rd_en_i = 0;
    @(negedge clk);
    chk("b_rd_valid", bus_b.rd_valid_o, 1);
    chk("b_data", bus_b.data_o, 128'hB0B00003_B0B00002_B0B00001_B0B00000);
    chk("b_tag", bus_b.tag_o, 21'h0BEEF);
    chk("b_valid", bus_b.valid_o, 1);
    @(negedge clk);
    chk("b_rd_valid_drop", bus_b.rd_valid_o, 0);
    chk("b_hold_data", bus_b.data_o, 128'hB0B00003_B0B00002_B0B00001_B0B00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
